ee357_alu: RTL and testbench

- 32-bit MIPS-style ALU for the multicycle CPU datapath.
- Performs add, subtract, logic, shift, set-less-than and JR passthrough, selected by the R-type funct field.
- Outputs are registered, with a result and four status flags: unsigned overflow, signed overflow, zero and carry-out.

---
 rtl/ee357_alu.sv | 128 ++++++++++++
 tb/tb_ee357_alu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ee357_alu.sv
// ee357_alu: 32-bit MIPS-style ALU for the multicycle CPU datapath.
// The operation is chosen by the R-type funct field. The result and the
// four status flags (uov, sov, zero, cout) are registered, so each
// operation has one cycle of latency. A new operation can start every cycle.
// Optional feature: define ALU_SLTU_EN to enable SLTU (funct 101011).
// When that macro is not defined, 101011 is handled as an unknown code.
module ee357_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic [5:0]  func,
  output logic [31:0] res,
  output logic        uov,
  output logic        sov,
  output logic        zero,
  output logic        cout
);

  typedef enum logic [5:0] {
    FN_SLL  = 6'b000000,
    FN_SRL  = 6'b000010,
    FN_SRA  = 6'b000011,
    FN_JR   = 6'b001000,
    FN_ADD  = 6'b100000,
    FN_SUB  = 6'b100010,
    FN_AND  = 6'b100100,
    FN_OR   = 6'b100101,
    FN_XOR  = 6'b100110,
    FN_NOR  = 6'b100111,
    FN_SLT  = 6'b101010,
    FN_SLTU = 6'b101011
  } func_e;

  logic        is_add;
  logic        is_sub;
  logic        use_arith;
  logic [31:0] b_op;
  logic [32:0] sum;
  logic        add_sov;
  logic        add_cout;
  logic        slt_bit;
  logic        sltu_bit;
  logic [4:0]  shamt;
  logic [31:0] res_c;
  logic        uov_c;
  logic        sov_c;
  logic        cout_c;

  // Decode which functions use the shared adder, and whether it subtracts.
  always_comb begin
    is_add = (func == FN_ADD);
    is_sub = (func == FN_SUB) || (func == FN_SLT);
`ifdef ALU_SLTU_EN
    if (func == FN_SLTU) is_sub = 1'b1;
`endif
    use_arith = is_add || is_sub;
  end

  // One adder handles ADD and SUB/SLT/SLTU: a - b is computed as a + ~b + 1.
  always_comb begin
    b_op     = is_sub ? ~opb : opb;
    sum      = {1'b0, opa} + {1'b0, b_op} + {32'b0, is_sub};
    add_cout = sum[32];
    // Overflow: the effective operands have the same sign and the sum's sign differs.
    // Using b_op covers both add and subtract with one expression.
    add_sov  = (opa[31] == b_op[31]) && (sum[31] != opa[31]);
    // Signed less-than: the sign of the difference, corrected by overflow.
    slt_bit  = sum[31] ^ add_sov;
    // Unsigned less-than: a borrow out of the subtraction.
    sltu_bit = ~sum[32];
    shamt    = opa[4:0];
  end

  // Select the result and the arithmetic flags for this funct code.
  always_comb begin
    res_c  = '0;
    uov_c  = 1'b0;
    sov_c  = 1'b0;
    cout_c = 1'b0;
    case (func)
      FN_ADD: res_c = sum[31:0];
      FN_SUB: res_c = sum[31:0];
      FN_AND: res_c = opa & opb;
      FN_OR:  res_c = opa | opb;
      FN_XOR: res_c = opa ^ opb;
      FN_NOR: res_c = ~(opa | opb);
      FN_SLT: res_c = {31'b0, slt_bit};
`ifdef ALU_SLTU_EN
      FN_SLTU: res_c = {31'b0, sltu_bit};
`endif
      FN_SLL: res_c = opb << shamt;
      FN_SRL: res_c = opb >> shamt;
      FN_SRA: res_c = $signed(opb) >>> shamt;
      FN_JR:  res_c = opa;
      default: res_c = '0;
    endcase
    if (use_arith) begin
      cout_c = add_cout;
      sov_c  = add_sov;
      // For ADD, uov is the carry out. For subtract-type functions it is the borrow.
      uov_c  = is_add ? add_cout : ~add_cout;
    end
  end

`ifndef ALU_SLTU_EN
  logic unused_sltu;
  assign unused_sltu = sltu_bit;
`endif

  // Output register: synchronous reset clears everything, including zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      res  <= '0;
      uov  <= 1'b0;
      sov  <= 1'b0;
      zero <= 1'b0;
      cout <= 1'b0;
    end else begin
      res  <= res_c;
      uov  <= uov_c;
      sov  <= sov_c;
      zero <= (res_c == '0);
      cout <= cout_c;
    end
  end

endmodule

// File: tb/tb_ee357_alu.sv
// Self-checking bench for ee357_alu: a directed vector table, hand-written
// sequences for latency and reset, and random stimulus checked against a
// behavioural reference model.
module tb_ee357_alu;

  logic        clk;
  logic        rst;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [5:0]  func;
  logic [31:0] res;
  logic        uov;
  logic        sov;
  logic        zero;
  logic        cout;

  int errors = 0;
  int checks = 0;

  ee357_alu dut (
    .clk  (clk),
    .rst  (rst),
    .opa  (opa),
    .opb  (opb),
    .func (func),
    .res  (res),
    .uov  (uov),
    .sov  (sov),
    .zero (zero),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100,
                         OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111,
                         SLT = 6'b101010, SLTU = 6'b101011, SLL = 6'b000000,
                         SRL = 6'b000010, SRA = 6'b000011, JR = 6'b001000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  f;
    logic [31:0] r;
    logic [3:0]  fl;   // {uov, sov, zero, cout}
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  fl;
  } exp_t;

  // Reference model. It works from plain integer arithmetic,
  // not from adder bit tricks.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [5:0] f);
    exp_t   e;
    longint sa, sb, s;
    logic   u, v, c;
    int     n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(a[4:0]);
    u = 1'b0; v = 1'b0; c = 1'b0;
    e.r = '0;
    case (f)
      ADD: begin
        s   = longint'(a) + longint'(b);
        e.r = s[31:0];
        c   = (s >= 64'sd4294967296);
        u   = c;
        s   = sa + sb;
        v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      SUB, SLT
`ifdef ALU_SLTU_EN
      , SLTU
`endif
      : begin
        s   = longint'(a) - longint'(b);
        e.r = s[31:0];
        u   = (a < b);
        c   = !(a < b);
        s   = sa - sb;
        v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        if (f == SLT)  e.r = (sa < sb) ? 32'd1 : 32'd0;
        if (f == SLTU) e.r = (a < b) ? 32'd1 : 32'd0;
      end
      AND_: e.r = a & b;
      OR_:  e.r = a | b;
      XOR_: e.r = a ^ b;
      NOR_: e.r = ~(a | b);
      SLL:  for (int i = 0; i < 32; i++) e.r[i] = (i >= n) ? b[i-n] : 1'b0;
      SRL:  for (int i = 0; i < 32; i++) e.r[i] = (i + n < 32) ? b[i+n] : 1'b0;
      SRA:  for (int i = 0; i < 32; i++) e.r[i] = (i + n < 32) ? b[i+n] : b[31];
      JR:   e.r = a;
      default: e.r = '0;
    endcase
    e.fl = {u, v, (e.r == 32'd0), c};
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] er, input logic [3:0] efl);
    checks++;
    if (res !== er || {uov, sov, zero, cout} !== efl) begin
      errors++;
      $display("FAIL %s: got res=%h flags=%b, expected res=%h flags=%b",
               name, res, {uov, sov, zero, cout}, er, efl);
    end
  endtask

  // Drive at the falling edge, then sample 1 time unit after the rising edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    @(negedge clk);
    opa = a; opb = b; func = f;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[19];
  exp_t e, e1, e2;
  logic [5:0] fsel[12];

  initial begin
    rst = 1'b1; opa = 32'hdeadbeef; opb = 32'h12345678; func = ADD;
    vecs[0]  = '{32'hffffffff, 32'h00000001, ADD,  32'h00000000, 4'b1011};
    vecs[1]  = '{32'h7fffffff, 32'h00000001, ADD,  32'h80000000, 4'b0100};
    vecs[2]  = '{32'h80000000, 32'h00000001, SUB,  32'h7fffffff, 4'b0101};
    vecs[3]  = '{32'h00000000, 32'h00000001, SUB,  32'hffffffff, 4'b1000};
    vecs[4]  = '{32'hffffffff, 32'hfffffffe, SUB,  32'h00000001, 4'b0001};
    vecs[5]  = '{32'hffffffff, 32'h0033ccff, AND_, 32'h0033ccff, 4'b0000};
    vecs[6]  = '{32'h00000000, 32'h0033ccff, OR_,  32'h0033ccff, 4'b0000};
    vecs[7]  = '{32'hffffffff, 32'h0033ccff, XOR_, 32'hffcc3300, 4'b0000};
    vecs[8]  = '{32'h00000000, 32'h0033ccff, NOR_, 32'hffcc3300, 4'b0000};
    vecs[9]  = '{32'h00000001, 32'h00000001, SLL,  32'h00000002, 4'b0000};
    vecs[10] = '{32'h0000001c, 32'h0000000a, SLL,  32'ha0000000, 4'b0000};
    vecs[11] = '{32'h00000001, 32'h80000000, SRL,  32'h40000000, 4'b0000};
    vecs[12] = '{32'h0000001f, 32'h80000000, SRL,  32'h00000001, 4'b0000};
    vecs[13] = '{32'h00000001, 32'h80000000, SRA,  32'hc0000000, 4'b0000};
    vecs[14] = '{32'h0000001f, 32'h80000000, SRA,  32'hffffffff, 4'b0000};
    vecs[15] = '{32'h00000000, 32'h00000001, SLT,  32'h00000001, 4'b1000};
    vecs[16] = '{32'hffffffff, 32'hfffffffe, SLT,  32'h00000000, 4'b0011};
    vecs[17] = '{32'h12345678, 32'h9abcdef0, JR,   32'h12345678, 4'b0000};
    vecs[18] = '{32'hffffffe0, 32'h87654321, SRL,  32'h87654321, 4'b0000};

    // Reset
    @(posedge clk); #1;
    check("reset", 32'h0, 4'b0000);
    @(negedge clk); rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].f);
      check($sformatf("vec%0d", i), vecs[i].r, vecs[i].fl);
    end

    // Unknown code, and SLTU (enabled or not)
    run_op(32'h5, 32'h9, 6'b111111);
    check("unknown", 32'h0, 4'b0010);
`ifdef ALU_SLTU_EN
    run_op(32'h1, 32'hffffffff, SLTU);
    check("sltu", 32'h1, 4'b1000);
`else
    run_op(32'h1, 32'hffffffff, SLTU);
    check("sltu_off", 32'h0, 4'b0010);
`endif

    // Back-to-back: the output must not change until the next edge.
    run_op(32'h7fffffff, 32'h1, ADD);
    check("b2b_first", 32'h80000000, 4'b0100);
    opa = 32'h0; opb = 32'h1; func = SUB;
    #1;
    check("b2b_hold", 32'h80000000, 4'b0100);
    @(posedge clk); #1;
    check("b2b_second", 32'hffffffff, 4'b1000);
    opa = 32'h12345678; func = JR;
    @(posedge clk); #1;
    check("b2b_third", 32'h12345678, 4'b0000);

    // Reset in the middle of a stream of operations
    @(negedge clk); rst = 1'b1; opa = 32'hffffffff; opb = 32'h1; func = ADD;
    @(posedge clk); #1;
    check("mid_reset", 32'h0, 4'b0000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset", 32'h0, 4'b1011);

    // Random stimulus checked against the model
    fsel = '{ADD, SUB, AND_, OR_, XOR_, NOR_, SLT, SLTU, SLL, SRL, SRA, JR};
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      logic [5:0]  f;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) b = a;
      f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fsel[$urandom_range(0, 11)];
      e = model(a, b, f);
      run_op(a, b, f);
      check($sformatf("rand%0d_f%b", i, f), e.r, e.fl);
    end

    // Random pairs of operations on consecutive cycles
    for (int i = 0; i < 50; i++) begin
      logic [31:0] a1, b1, a2, b2;
      logic [5:0]  f1, f2;
      a1 = $urandom; b1 = $urandom; f1 = fsel[$urandom_range(0, 11)];
      a2 = $urandom; b2 = $urandom; f2 = fsel[$urandom_range(0, 11)];
      e1 = model(a1, b1, f1);
      e2 = model(a2, b2, f2);
      run_op(a1, b1, f1);
      check("pair_a", e1.r, e1.fl);
      opa = a2; opb = b2; func = f2;
      @(posedge clk); #1;
      check("pair_b", e2.r, e2.fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
